// File: rtl/fwd_select_unit_pkg.sv
// fwd_select_unit_pkg
// Shared definitions for the operand-forwarding controller:
//   - fwd_sel_e : EX operand mux select encodings
//   - fwd_tag_t : one in-flight tag slot {v, rd, we, ld}
//   - tag_match : does a slot produce the value a given source register needs
// The rd field is sized to FWD_RD_W so the struct can live in the package.
// Narrower register indices are zero-extended into it, so REG_ADDR_W must
// not exceed FWD_RD_W.
package fwd_select_unit_pkg;

  localparam int FWD_RD_W = 8;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,  // register file
    FWD_MEM  = 2'b01,  // MEM-stage result
    FWD_WB   = 2'b10,  // WB-stage result
    FWD_HOLD = 2'b11   // retired-result hold register
  } fwd_sel_e;

  typedef struct packed {
    logic                v;
    logic [FWD_RD_W-1:0] rd;
    logic                we;
    logic                ld;
  } fwd_tag_t;

  // x0 is hardwired zero and never a forwarding target.
  function automatic logic tag_match(fwd_tag_t t, logic [FWD_RD_W-1:0] s);
    return t.v & t.we & (t.rd == s) & (s != '0);
  endfunction

endpackage

// File: rtl/fwd_select_unit_if.sv
// fwd_select_unit_if
// Decode-side request and EX-side select bundle of the forwarding controller.
//   master : decode / testbench side (drives id_*, flush; observes results)
//   slave  : fwd_select_unit side
// Signals:
//   id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, flush  (decode -> unit)
//   ex_sel_a, ex_sel_b, stall, perf_stalls                   (unit -> pipeline)
interface fwd_select_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_we;
  logic                  id_load;
  logic                  flush;
  logic [1:0]            ex_sel_a;
  logic [1:0]            ex_sel_b;
  logic                  stall;
  logic [CNT_W-1:0]      perf_stalls;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, flush,
    input  ex_sel_a, ex_sel_b, stall, perf_stalls
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, flush,
    output ex_sel_a, ex_sel_b, stall, perf_stalls
  );
endinterface

// File: rtl/fwd_select_unit_tag_pipe.sv
// fwd_tag_pipe
// Three-slot tag shift register tracking in-flight destinations in EX, MEM
// and WB. Every cycle WB<-MEM and MEM<-EX; EX takes the decode tag when
// adv_i is high, otherwise a bubble (v=0).
// Ports:
//   clk, reset : clock, async active-high reset (clears all slots)
//   adv_i      : decode instruction is issued into EX this cycle
//   id_tag_i   : tag of the decode instruction
//   ex_o/mem_o/wb_o : current slot contents
module fwd_tag_pipe
  import fwd_select_unit_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     adv_i,
  input  fwd_tag_t id_tag_i,
  output fwd_tag_t ex_o,
  output fwd_tag_t mem_o,
  output fwd_tag_t wb_o
);

  fwd_tag_t ex_q, mem_q, wb_q;
  fwd_tag_t ex_d;

  always_comb begin
    ex_d = '0;
    if (adv_i) ex_d = id_tag_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/fwd_select_unit.sv
// fwd_select_unit
// Operand-forwarding controller for the 5-stage integer pipeline. Sits in ID
// and computes the EX operand mux selects one cycle ahead, plus the
// load-use stall.
// Ports:
//   clk, reset : pipeline clock, async active-high reset
//   bus        : fwd_select_unit_if.slave
//                  in : id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, flush
//                  out: ex_sel_a, ex_sel_b (registered), stall (combinational),
//                       perf_stalls (saturating stall-cycle count)
// REG_ADDR_W / CNT_W must match the widths of the connected interface.
module fwd_select_unit
  import fwd_select_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  fwd_select_unit_if.slave bus
);

  logic [REG_ADDR_W-1:0] rs1_w, rs2_w, rd_w;
  logic [FWD_RD_W-1:0]   rs1_x, rs2_x;
  fwd_tag_t              id_tag, ex_t, mem_t, wb_t;
  logic                  issue, stall, adv;
  fwd_sel_e              sel_a_d, sel_b_d;
  logic [1:0]            sel_a_q, sel_b_q;
  logic [CNT_W-1:0]      perf_q;

  assign rs1_w = bus.id_rs1;
  assign rs2_w = bus.id_rs2;
  assign rd_w  = bus.id_rd;
  assign rs1_x = FWD_RD_W'(rs1_w);
  assign rs2_x = FWD_RD_W'(rs2_w);

  always_comb begin
    id_tag    = '0;
    id_tag.v  = 1'b1;
    id_tag.rd = FWD_RD_W'(rd_w);
    id_tag.we = bus.id_we;
    id_tag.ld = bus.id_load;
  end

  // A load in EX cannot feed the instruction in ID until it reaches MEM's
  // output, so hold ID for one cycle. Flush wins: the squashed instruction
  // needs no operands.
  assign issue = bus.id_valid & ~bus.flush;
  assign stall = issue & ex_t.ld &
                 (tag_match(ex_t, rs1_x) | tag_match(ex_t, rs2_x));
  assign adv   = issue & ~stall;

  fwd_tag_pipe u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .adv_i    (adv),
    .id_tag_i (id_tag),
    .ex_o     (ex_t),
    .mem_o    (mem_t),
    .wb_o     (wb_t)
  );

  // Youngest producer wins. The instruction now in EX will be in MEM when the
  // consumer is in EX, hence the one-stage shift in the encodings. A load in
  // EX never reaches here with a match because it stalls instead.
  function automatic fwd_sel_e pick(logic [FWD_RD_W-1:0] s);
    if (tag_match(ex_t, s) && !ex_t.ld) return FWD_MEM;
    else if (tag_match(mem_t, s))       return FWD_WB;
    else if (tag_match(wb_t, s))        return FWD_HOLD;
    else                                return FWD_RF;
  endfunction

  always_comb begin
    sel_a_d = FWD_RF;
    sel_b_d = FWD_RF;
    if (adv) begin
      sel_a_d = pick(rs1_x);
      sel_b_d = pick(rs2_x);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
      perf_q  <= '0;
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      if (stall && perf_q != '1) perf_q <= perf_q + CNT_W'(1);
    end
  end

  assign bus.ex_sel_a    = sel_a_q;
  assign bus.ex_sel_b    = sel_b_q;
  assign bus.stall       = stall;
  assign bus.perf_stalls = perf_q;

endmodule

// File: tb/tb_fwd_select_unit.sv
module tb_fwd_select_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  fwd_select_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
  fwd_select_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  bus_s ();

  fwd_select_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  // narrow-counter copy, shares stimulus, used for saturation
  fwd_select_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  assign bus_s.id_valid = bus.id_valid;
  assign bus_s.id_rs1   = bus.id_rs1;
  assign bus_s.id_rs2   = bus.id_rs2;
  assign bus_s.id_rd    = bus.id_rd;
  assign bus_s.id_we    = bus.id_we;
  assign bus_s.id_load  = bus.id_load;
  assign bus_s.flush    = bus.flush;

  always #5 clk = ~clk;

  task automatic id(input logic v, input logic [4:0] rs1, rs2, rd,
                    input logic we, ld);
    bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_we = we; bus.id_load = ld; bus.flush = 1'b0;
  endtask

  task automatic nop;
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // async pulse placed between edges
  task automatic do_reset;
    nop(); reset = 1'b1; #2; reset = 1'b0;
  endtask

  task automatic test_reset;
    nop(); #1;
    vecs++; if (bus.ex_sel_a !== 2'b00 || bus.ex_sel_b !== 2'b00) begin
      errs++; $display("FAIL reset_sel: got %b/%b want 00/00", bus.ex_sel_a, bus.ex_sel_b); end
    vecs++; if (bus.stall !== 1'b0 || bus.perf_stalls !== 16'd0) begin
      errs++; $display("FAIL reset_stall_perf: got %b/%0d want 0/0", bus.stall, bus.perf_stalls); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ex_fwd;
    do_reset();
    id(1, 5'd1, 5'd2, 5'd3, 1, 0); step();      // ADD x3,x1,x2
    id(1, 5'd3, 5'd5, 5'd4, 1, 0); #1;          // SUB x4,x3,x5
    vecs++; if (bus.stall !== 1'b0) begin
      errs++; $display("FAIL ex_fwd_stall: got %b want 0", bus.stall); end
    step(); nop();
    vecs++; if (bus.ex_sel_a !== 2'b01 || bus.ex_sel_b !== 2'b00) begin
      errs++; $display("FAIL ex_fwd_sel: got %b/%b want 01/00", bus.ex_sel_a, bus.ex_sel_b); end
  endtask

  // producer x3, then n NOPs, then ADD x6,x7,x3
  task automatic test_distance(input int n, input logic [1:0] want);
    do_reset();
    id(1, 5'd1, 5'd2, 5'd3, 1, 0); step();
    for (int i = 0; i < n; i++) begin nop(); step(); end
    id(1, 5'd7, 5'd3, 5'd6, 1, 0); step(); nop();
    vecs++; if (bus.ex_sel_a !== 2'b00 || bus.ex_sel_b !== want) begin
      errs++; $display("FAIL distance_%0d: got %b/%b want 00/%b", n, bus.ex_sel_a, bus.ex_sel_b, want); end
  endtask

  task automatic test_load_use;
    do_reset();
    id(1, 5'd1, 5'd0, 5'd8, 1, 1); step();      // LW x8
    id(1, 5'd8, 5'd8, 5'd9, 1, 0); #1;          // ADD x9,x8,x8
    vecs++; if (bus.stall !== 1'b1 || bus.perf_stalls !== 16'd0) begin
      errs++; $display("FAIL lu_stall_on: got %b/%0d want 1/0", bus.stall, bus.perf_stalls); end
    step();
    vecs++; if (bus.ex_sel_a !== 2'b00 || bus.ex_sel_b !== 2'b00) begin
      errs++; $display("FAIL lu_bubble_sel: got %b/%b want 00/00", bus.ex_sel_a, bus.ex_sel_b); end
    vecs++; if (bus.stall !== 1'b0 || bus.perf_stalls !== 16'd1) begin
      errs++; $display("FAIL lu_stall_off: got %b/%0d want 0/1", bus.stall, bus.perf_stalls); end
    step();
    vecs++; if (bus.ex_sel_a !== 2'b10 || bus.ex_sel_b !== 2'b10) begin
      errs++; $display("FAIL lu_reissue_sel: got %b/%b want 10/10", bus.ex_sel_a, bus.ex_sel_b); end
    // mid-stream async reset: EX=ADD x9, WB=LW x8, consumer reads x9,x8
    id(1, 5'd9, 5'd8, 5'd10, 1, 0);
    reset = 1'b1; #1;
    vecs++; if (bus.ex_sel_a !== 2'b00 || bus.ex_sel_b !== 2'b00 || bus.stall !== 1'b0
                || bus.perf_stalls !== 16'd0) begin
      errs++; $display("FAIL async_reset: got %b/%b/%b/%0d want 00/00/0/0",
                       bus.ex_sel_a, bus.ex_sel_b, bus.stall, bus.perf_stalls); end
    #1; reset = 1'b0;
    step(); nop();
    vecs++; if (bus.ex_sel_a !== 2'b00 || bus.ex_sel_b !== 2'b00) begin
      errs++; $display("FAIL post_reset_sel: got %b/%b want 00/00", bus.ex_sel_a, bus.ex_sel_b); end
  endtask

  task automatic test_x0;
    do_reset();
    id(1, 5'd1, 5'd2, 5'd0, 1, 0); step();      // ADD x0
    id(1, 5'd1, 5'd2, 5'd0, 1, 0); step();      // ADD x0
    id(1, 5'd1, 5'd0, 5'd0, 1, 1); step();      // LW x0
    id(1, 5'd0, 5'd0, 5'd5, 1, 0); #1;          // ADD x5,x0,x0
    vecs++; if (bus.stall !== 1'b0) begin
      errs++; $display("FAIL x0_stall: got %b want 0", bus.stall); end
    step(); nop();
    vecs++; if (bus.ex_sel_a !== 2'b00 || bus.ex_sel_b !== 2'b00) begin
      errs++; $display("FAIL x0_sel: got %b/%b want 00/00", bus.ex_sel_a, bus.ex_sel_b); end
  endtask

  task automatic test_flush;
    do_reset();
    id(1, 5'd1, 5'd0, 5'd8, 1, 1); step();      // LW x8
    id(1, 5'd8, 5'd8, 5'd8, 1, 0); bus.flush = 1'b1; #1;  // flushed ADD x8
    vecs++; if (bus.stall !== 1'b0) begin
      errs++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
    step();
    vecs++; if (bus.perf_stalls !== 16'd0 || bus.ex_sel_a !== 2'b00) begin
      errs++; $display("FAIL flush_bubble: got %0d/%b want 0/00", bus.perf_stalls, bus.ex_sel_a); end
    // EX must hold a bubble, so x8 comes from the load now in MEM
    id(1, 5'd8, 5'd1, 5'd11, 1, 0); step(); nop();
    vecs++; if (bus.ex_sel_a !== 2'b10 || bus.ex_sel_b !== 2'b00) begin
      errs++; $display("FAIL flush_after: got %b/%b want 10/00", bus.ex_sel_a, bus.ex_sel_b); end
  endtask

  task automatic test_shadow;
    do_reset();
    id(1, 5'd1, 5'd2, 5'd3, 1, 0); step();
    id(1, 5'd1, 5'd2, 5'd3, 1, 0); step();
    id(1, 5'd3, 5'd3, 5'd4, 1, 0); step(); nop();
    vecs++; if (bus.ex_sel_a !== 2'b01 || bus.ex_sel_b !== 2'b01) begin
      errs++; $display("FAIL shadow_ex_mem: got %b/%b want 01/01", bus.ex_sel_a, bus.ex_sel_b); end
    do_reset();
    id(1, 5'd1, 5'd2, 5'd3, 1, 0); step();
    id(1, 5'd1, 5'd2, 5'd3, 1, 0); step();
    nop(); step();
    id(1, 5'd3, 5'd0, 5'd4, 1, 0); step(); nop();
    vecs++; if (bus.ex_sel_a !== 2'b10) begin
      errs++; $display("FAIL shadow_mem_wb: got %b want 10", bus.ex_sel_a); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    id(1, 5'd1, 5'd0, 5'd8, 1, 1); step();      // LW x8
    id(1, 5'd8, 5'd0, 5'd9, 1, 1); #1;          // LW x9,0(x8)
    vecs++; if (bus.stall !== 1'b1) begin
      errs++; $display("FAIL b2b_stall1: got %b want 1", bus.stall); end
    step(); step();                              // bubble, then LW x9 in EX
    vecs++; if (bus.ex_sel_a !== 2'b10) begin
      errs++; $display("FAIL b2b_sel1: got %b want 10", bus.ex_sel_a); end
    id(1, 5'd9, 5'd0, 5'd10, 1, 0); #1;         // ADD x10,x9
    vecs++; if (bus.stall !== 1'b1) begin
      errs++; $display("FAIL b2b_stall2: got %b want 1", bus.stall); end
    step(); step(); nop();
    vecs++; if (bus.ex_sel_a !== 2'b10 || bus.perf_stalls !== 16'd2) begin
      errs++; $display("FAIL b2b_end: got %b/%0d want 10/2", bus.ex_sel_a, bus.perf_stalls); end
  endtask

  task automatic test_saturate;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      id(1, 5'd1, 5'd0, 5'd8, 1, 1); step();
      id(1, 5'd8, 5'd0, 5'd9, 1, 0); step(); step();
      if (i == 2) begin
        vecs++; if (bus_s.perf_stalls !== 2'd3 || bus.perf_stalls !== 16'd3) begin
          errs++; $display("FAIL sat_at3: got %0d/%0d want 3/3", bus_s.perf_stalls, bus.perf_stalls); end
      end
    end
    nop();
    vecs++; if (bus_s.perf_stalls !== 2'd3 || bus.perf_stalls !== 16'd4) begin
      errs++; $display("FAIL sat_hold: got %0d/%0d want 3/4", bus_s.perf_stalls, bus.perf_stalls); end
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_distance(1, 2'b10);
    test_distance(2, 2'b11);
    test_distance(3, 2'b00);
    test_load_use();
    test_x0();
    test_flush();
    test_shadow();
    test_back_to_back();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
